udma_i2c_prefetch_fifo: RTL and testbench
=========================================

// Module: udma_i2c_prefetch_fifo
// PURPOSE
//   Prefetching FIFO on the sys_clk_i side of the I2C uDMA peripheral. It sits between a uDMA
//   channel (command or TX data) and the clock-domain-crossing FIFO toward the I2C controller.
//   It requests words from the uDMA arbiter with req/gnt, then accepts the returned data on
//   valid_i. It issues a request only while a free storage slot is reserved for the reply, so
//   returned data is never dropped. Stored words are presented on a valid/ready output.
// PARAMETERS
//   DATA_WIDTH    32  width of data_i/data_o (32 for commands, 8 for TX data)
//   BUFFER_DEPTH   2  number of storage slots; legal range >= 2
// PORTS
//   clk_i       in   1           sys clock
//   rstn_i      in   1           asynchronous active-low reset
//   clr_i       in   1           synchronous flush of stored words
//   req_o       out  1           request to uDMA arbiter
//   gnt_i       in   1           grant; a transfer is counted when req_o && gnt_i
//   valid_i     in   1           returned data valid
//   data_i      in   DATA_WIDTH  returned data
//   ready_o     out  1           storage can accept data_i
//   valid_o     out  1           data_o holds a stored word
//   data_o      out  DATA_WIDTH  oldest stored word
//   ready_i     in   1           downstream consumes data_o
//   elements_o  out  CW          stored-word count, CW = $clog2(BUFFER_DEPTH+1)
// BEHAVIOUR
//   - State:
//     - circular buffer of BUFFER_DEPTH x DATA_WIDTH;
//     - wr_ptr and rd_ptr, each $clog2(BUFFER_DEPTH) bits, wrapping from BUFFER_DEPTH-1 to 0,
//       so non-power-of-2 depths are supported;
//     - elements and outstanding counters, each CW bits.
//   - Reset (rstn_i low): pointers, elements, outstanding and storage all 0.
//     Outputs during reset: valid_o=0, data_o=0, ready_o=1, elements_o=0, req_o=1.
//   - req_o is combinational: (elements + outstanding) < BUFFER_DEPTH && !clr_i.
//     The sum is computed CW+1 bits wide to prevent overflow.
//   - Grant: req_o && gnt_i -> outstanding+1 next cycle. gnt_i while req_o=0 is ignored.
//   - Push: valid_i && ready_o -> data_i written at wr_ptr; wr_ptr and elements advance.
//     outstanding-1, saturating at 0, so an unsolicited valid_i is stored without underflow.
//   - ready_o = (elements < BUFFER_DEPTH), taken from registered state only.
//     While full, ready_o=0 even in a pop cycle.
//   - Pop: valid_o && ready_i -> rd_ptr and elements advance.
//     valid_o = (elements != 0); data_o = mem[rd_ptr].
//   - Latency: a word pushed in cycle N is visible on data_o/valid_o in cycle N+1.
//     No combinational fall-through from data_i to data_o.
//   - Simultaneous push+pop: elements unchanged; both pointers advance.
//   - Simultaneous grant and return in one cycle: outstanding unchanged.
//   - Invariant: elements + outstanding <= BUFFER_DEPTH at all times. Assertion: the sum never
//     exceeds BUFFER_DEPTH.
//   - clr_i: next cycle, wr_ptr=rd_ptr=elements=0 and valid_o=0. req_o is held low while
//     clr_i=1. outstanding is NOT cleared; data returned after the flush for earlier grants is
//     stored normally into its reserved slot. Push and pop in the clr_i cycle are discarded.
//   - Asynchronous reset mid-transfer returns all state to the reset values above; in-flight
//     grants are forgotten.
// TESTING
//   1. Reset, gnt_i=1, ready_i=0, data returned 2 cycles after each grant ->
//      exactly 2 grants counted; req_o falls once elements+outstanding=2.
//      Words 0xA5A5_0001 and 0xA5A5_0002 are output in order when ready_i rises.
//   2. gnt_i always 1, ready_i always 1, 1-cycle return latency -> sustained 1 word/cycle after
//      fill. valid_i never arrives with ready_o=0. Output order matches input order across
//      100 words.
//   3. BUFFER_DEPTH=3, 10 random push/pop bursts -> pointers wrap 2->0 and order is preserved.
//      elements_o tracks the scoreboard count every cycle.
//   4. Full FIFO; in one cycle valid_i=1 and ready_i=1 -> push refused (ready_o=0), pop done,
//      elements 3->2. The following cycle, the push is accepted.
//   5. 1 word stored and 1 grant outstanding; pulse clr_i -> valid_o=0 next cycle and req_o=0
//      during the pulse. The late word is stored and elements_o=1 after it arrives.
//   6. Assert rstn_i low with outstanding=2 and elements=1 -> all outputs at reset values
//      immediately. After release, req_o=1 and counts restart from 0.

Source files
------------

// File: rtl/udma_i2c_prefetch_fifo.sv
// Prefetching FIFO between a uDMA channel and the I2C CDC FIFO. A request is only issued
// while a storage slot is reserved for its reply, so returned data is never dropped.
module udma_i2c_prefetch_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 2,
    localparam int CW = $clog2(BUFFER_DEPTH + 1),
    localparam int PW = $clog2(BUFFER_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    output logic                  req_o,
    input  logic                  gnt_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [CW-1:0]         elements_o
);

    logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_elements;
    logic [CW-1:0]         r_outstanding;

    logic [CW:0]           w_sum;
    logic                  w_grant;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Extra bit on the sum keeps the comparison exact when both counters are near full.
    assign w_sum      = {1'b0, r_elements} + {1'b0, r_outstanding};
    assign req_o      = (w_sum < (CW+1)'(BUFFER_DEPTH)) && !clr_i;
    assign ready_o    = (r_elements < CW'(BUFFER_DEPTH));
    assign valid_o    = (r_elements != '0);
    assign data_o     = r_mem[r_rd_ptr];
    assign elements_o = r_elements;

    assign w_grant = req_o && gnt_i;
    assign w_push  = valid_i && ready_o;
    assign w_pop   = valid_o && ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !clr_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_elements <= '0;
        end else if (clr_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_elements <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_elements <= r_elements + CW'(1);
                2'b01:   r_elements <= r_elements - CW'(1);
                default: r_elements <= r_elements;
            endcase
        end
    end

    // A reply landing in a flush cycle is dropped but still retires its grant,
    // otherwise its reserved slot would stay booked forever.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_grant, w_push})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= (r_outstanding == '0) ? '0 : r_outstanding - CW'(1);
                2'b11:   r_outstanding <= (r_outstanding == '0) ? CW'(1) : r_outstanding;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    a_no_overbook: assert property (@(posedge clk_i) disable iff (!rstn_i)
        w_sum <= (CW+1)'(BUFFER_DEPTH));

endmodule

// File: tb/tb_udma_i2c_prefetch_fifo.sv
// Directed bench: depth-2 and depth-3 instances exercised one after the other.
module tb_udma_i2c_prefetch_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        clr2, gnt2, vin2, rdy2, req2, ordy2, vout2;
    logic [31:0] din2, dout2;
    logic [1:0]  el2;
    logic        clr3, gnt3, vin3, rdy3, req3, ordy3, vout3;
    logic [31:0] din3, dout3;
    logic [1:0]  el3;

    int n_cmp = 0;
    int n_err = 0;

    udma_i2c_prefetch_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(2)) u_dut2 (
        .clk_i(clk), .rstn_i(rstn), .clr_i(clr2), .req_o(req2), .gnt_i(gnt2),
        .valid_i(vin2), .data_i(din2), .ready_o(ordy2), .valid_o(vout2),
        .data_o(dout2), .ready_i(rdy2), .elements_o(el2));

    udma_i2c_prefetch_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(3)) u_dut3 (
        .clk_i(clk), .rstn_i(rstn), .clr_i(clr3), .req_o(req3), .gnt_i(gnt3),
        .valid_i(vin3), .data_i(din3), .ready_o(ordy3), .valid_o(vout3),
        .data_o(dout3), .ready_i(rdy3), .elements_o(el3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        {clr2, gnt2, vin2, rdy2} = '0; din2 = '0;
        {clr3, gnt3, vin3, rdy3} = '0; din3 = '0;
    endtask

    task automatic hard_reset;
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gcnt, k, popped, first, last, seq, mode, len;
        logic        g, push_ok, pop_ok;
        logic [1:0]  gp;
        logic [31:0] q[$];

        // ---- 1: reset values, then two 2-cycle-latency grants fill depth 2
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o", 32'(vout2), 32'd0);
        chk("rst_data_o",  dout2,      32'd0);
        chk("rst_ready_o", 32'(ordy2), 32'd1);
        chk("rst_elem",    32'(el2),   32'd0);
        chk("rst_req_o",   32'(req2),  32'd1);
        rstn = 1'b1;
        gnt2 = 1'b1; gp = '0; gcnt = 0; k = 0;
        for (int c = 0; c < 8; c++) begin
            vin2 = gp[1];
            din2 = 32'hA5A5_0001 + 32'(k);
            #1;
            g = req2 && gnt2;
            gcnt += int'(g);
            if (vin2) k++;
            tick();
            gp = {gp[0], g};
        end
        vin2 = 1'b0;
        chk("t1_grants",   32'(gcnt),  32'd2);
        chk("t1_req_low",  32'(req2),  32'd0);
        chk("t1_elem",     32'(el2),   32'd2);
        chk("t1_ready_o",  32'(ordy2), 32'd0);
        gnt2 = 1'b0; rdy2 = 1'b1;
        #1;
        chk("t1_word0",    dout2,      32'hA5A5_0001);
        tick();
        chk("t1_word1",    dout2,      32'hA5A5_0002);
        chk("t1_elem1",    32'(el2),   32'd1);
        tick();
        chk("t1_empty",    32'(vout2), 32'd0);
        rdy2 = 1'b0;

        // ---- 2: depth 3, 1-cycle return, full-rate streaming of 100 words
        hard_reset();
        q = {}; gp = '0; k = 0; popped = 0; first = -1; last = -1;
        for (int c = 0; c < 400 && popped < 100; c++) begin
            vin3 = gp[0];
            din3 = 32'h0000_1000 + 32'(k);
            gnt3 = 1'b1; rdy3 = 1'b1;
            #1;
            g = req3 && gnt3;
            if (vout3) begin
                chk("t2_order", dout3, (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF);
                popped++;
                if (first < 0) first = c;
                last = c;
            end
            if (vin3) begin
                chk("t2_ready_on_valid", 32'(ordy3), 32'd1);
                q.push_back(din3);
                k++;
            end
            tick();
            gp[0] = g;
        end
        chk("t2_popped",     32'(popped),       32'd100);
        chk("t2_throughput", 32'(last - first), 32'd99);

        // ---- 3: depth 3 random push/pop bursts against a scoreboard
        hard_reset();
        q = {}; seq = 0;
        for (int b = 0; b < 10; b++) begin
            mode = int'($urandom_range(0, 2));
            len  = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                vin3 = (mode != 1);
                rdy3 = (mode != 0);
                din3 = 32'hB000_0000 + 32'(seq);
                #1;
                chk("t3_elem",  32'(el3),   32'(q.size()));
                chk("t3_ready", 32'(ordy3), 32'(q.size() < 3));
                pop_ok  = rdy3 && (q.size() > 0);
                push_ok = vin3 && (q.size() < 3);
                if (pop_ok) chk("t3_data", dout3, q[0]);
                tick();
                if (pop_ok) void'(q.pop_front());
                if (push_ok) begin q.push_back(din3); seq++; end
            end
        end

        // ---- 4: full FIFO, push+pop in one cycle refuses the push
        rdy3 = 1'b0;
        for (int j = 0; j < 4 && q.size() < 3; j++) begin
            vin3 = 1'b1;
            din3 = 32'hB000_0000 + 32'(seq);
            tick();
            q.push_back(din3); seq++;
        end
        vin3 = 1'b1; rdy3 = 1'b1; din3 = 32'hC0C0_0004;
        #1;
        chk("t4_ready_full", 32'(ordy3), 32'd0);
        chk("t4_elem_full",  32'(el3),   32'd3);
        chk("t4_pop_data",   dout3,      q[0]);
        tick();
        void'(q.pop_front());
        chk("t4_elem_after", 32'(el3),   32'd2);
        rdy3 = 1'b0;
        #1;
        chk("t4_ready_again", 32'(ordy3), 32'd1);
        tick();
        q.push_back(32'hC0C0_0004);
        vin3 = 1'b0;
        chk("t4_elem_refill", 32'(el3), 32'd3);
        rdy3 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("t4_drain", dout3, q[0]);
            tick();
            void'(q.pop_front());
        end
        chk("t4_drained", 32'(vout3), 32'd0);

        // ---- 5: flush with one word stored and one grant outstanding
        hard_reset();
        gnt2 = 1'b1;
        tick();
        vin2 = 1'b1; din2 = 32'hC0DE_0001;
        tick();
        vin2 = 1'b0; clr2 = 1'b1;
        #1;
        chk("t5_req_in_clr",   32'(req2),  32'd0);
        chk("t5_valid_pre",    32'(vout2), 32'd1);
        tick();
        clr2 = 1'b0; gnt2 = 1'b0;
        #1;
        chk("t5_valid_flush",  32'(vout2), 32'd0);
        chk("t5_elem_flush",   32'(el2),   32'd0);
        vin2 = 1'b1; din2 = 32'hC0DE_0002;
        tick();
        vin2 = 1'b0;
        chk("t5_late_elem",    32'(el2),   32'd1);
        chk("t5_late_data",    dout2,      32'hC0DE_0002);
        chk("t5_req_after",    32'(req2),  32'd1);

        // ---- 6: async reset with outstanding=2, elements=1
        hard_reset();
        gnt3 = 1'b1;
        tick();
        tick();
        vin3 = 1'b1; din3 = 32'hD00D_0001;
        tick();
        vin3 = 1'b0; gnt3 = 1'b0;
        chk("t6_pre_req", 32'(req3), 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_elem",  32'(el3),   32'd0);
        chk("t6_rst_valid", 32'(vout3), 32'd0);
        chk("t6_rst_data",  dout3,      32'd0);
        chk("t6_rst_ready", 32'(ordy3), 32'd1);
        chk("t6_rst_req",   32'(req3),  32'd1);
        tick();
        rstn = 1'b1;
        gnt3 = 1'b1;
        #1;
        chk("t6_req_release", 32'(req3), 32'd1);
        tick();
        gnt3 = 1'b0; vin3 = 1'b1; din3 = 32'hD00D_0002;
        tick();
        vin3 = 1'b0;
        chk("t6_restart_elem", 32'(el3),  32'd1);
        chk("t6_restart_data", dout3,     32'hD00D_0002);
        chk("t6_restart_req",  32'(req3), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
